// File: rtl/sram1024x18_arbiter_pkg.sv
// Shared widths, FSM state and command record for the sram1024x18 port arbiter.
package sram_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 18;
    localparam int DEPTH  = 1024;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] wmsk;
    } cmd_t;

endpackage

// File: rtl/sram1024x18_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational grant, pointer flips to the other side on every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import sram_arb_pkg::*;

    // 0: r0 wins a tie, 1: r1 wins a tie
    logic prio_reg;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req[0] && (!req[1] || !prio_reg)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= 1'b0;
        end else if (gnt[0]) begin
            prio_reg <= 1'b1;
        end else if (gnt[1]) begin
            prio_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/sram1024x18_arbiter.sv
// Two-client arbiter/sequencer for one sram1024x18 port.
// Define SRAM1024X18_ARB_ZERO_INIT_EN to zero-fill the array after reset before serving clients.
module sram1024x18_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [DATA_W-1:0] r0_wmsk,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [DATA_W-1:0] r1_wmsk,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wmsk,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_busy
);
    import sram_arb_pkg::*;

    logic              run_en;
    logic              in_init;
    logic [ADDR_W-1:0] init_addr;
    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [1:0]        gnt;
    logic [1:0]        rvalid_reg;
    cmd_t              cmd [2];
    cmd_t              sel;

`ifdef SRAM1024X18_ARB_ZERO_INIT_EN
    state_t            state_reg;
    logic [ADDR_W-1:0] init_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
        end else if (state_reg == INIT) begin
            init_cnt_reg <= init_cnt_reg + 1'b1;
            if (init_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                state_reg <= RUN;
            end
        end
    end

    assign init_busy = (state_reg == INIT);
    // Reset gating keeps the macro deselected while rst_n is low
    assign in_init   = rst_n && (state_reg == INIT);
    assign run_en    = rst_n && (state_reg == RUN);
    assign init_addr = init_cnt_reg;
`else
    assign init_busy = 1'b0;
    assign in_init   = 1'b0;
    assign run_en    = rst_n;
    assign init_addr = '0;
`endif

    assign req_vec = {r1_req, r0_req};
    assign we_vec  = {r1_we, r0_we};
    assign cmd[0]  = '{we: r0_we, addr: r0_addr, wdata: r0_wdata, wmsk: r0_wmsk};
    assign cmd[1]  = '{we: r1_we, addr: r1_addr, wdata: r1_wdata, wmsk: r1_wmsk};
    assign sel     = gnt[1] ? cmd[1] : cmd[0];

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (run_en),
        .req    (req_vec),
        .gnt    (gnt)
    );

    assign r0_gnt = gnt[0];
    assign r1_gnt = gnt[1];

    always_comb begin
        sram_cen   = 1'b1;
        sram_wen   = 1'b1;
        sram_addr  = '0;
        sram_wmsk  = '1;
        sram_wdata = '0;
        if (in_init) begin
            sram_cen  = 1'b0;
            sram_wen  = 1'b0;
            sram_addr = init_addr;
            sram_wmsk = '0;
        end else if (gnt != 2'b00) begin
            sram_cen   = 1'b0;
            sram_wen   = !sel.we;
            sram_addr  = sel.addr;
            sram_wmsk  = sel.wmsk;
            sram_wdata = sel.wdata;
        end
    end

    // Read strobe lines up with the macro's registered read data
    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_reg[gi] <= 1'b0;
            end else begin
                rvalid_reg[gi] <= gnt[gi] && !we_vec[gi];
            end
        end
    end

    assign r0_rvalid = rvalid_reg[0];
    assign r1_rvalid = rvalid_reg[1];
    assign r0_rdata  = sram_rdata;
    assign r1_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram1024x18_arbiter.sv
// Scoreboard bench for sram1024x18_arbiter with a behavioural model of the macro port.
// Zero-fill checks are compiled in when SRAM1024X18_ARB_ZERO_INIT_EN is defined.
module tb_sram1024x18_arbiter;

`ifdef SRAM1024X18_ARB_ZERO_INIT_EN
    localparam logic [17:0] FILL     = 18'h00000;
    localparam logic        BUSY_RST = 1'b1;
`else
    localparam logic [17:0] FILL     = 18'h3FFFF;
    localparam logic        BUSY_RST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        r0_req, r0_we, r0_gnt, r0_rvalid;
    logic [9:0]  r0_addr;
    logic [17:0] r0_wdata, r0_wmsk, r0_rdata;
    logic        r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [9:0]  r1_addr;
    logic [17:0] r1_wdata, r1_wmsk, r1_rdata;
    logic        sram_cen, sram_wen, init_busy;
    logic [9:0]  sram_addr;
    logic [17:0] sram_wmsk, sram_wdata, sram_rdata;

    logic [17:0] mem [0:1023];
    logic [17:0] q0 [$];
    logic [17:0] q1 [$];
    logic [17:0] exp0, exp1;
    int pass_cnt  = 0;
    int total_cnt = 0;

    sram1024x18_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r0_req     (r0_req),
        .r0_we      (r0_we),
        .r0_addr    (r0_addr),
        .r0_wdata   (r0_wdata),
        .r0_wmsk    (r0_wmsk),
        .r0_gnt     (r0_gnt),
        .r0_rvalid  (r0_rvalid),
        .r0_rdata   (r0_rdata),
        .r1_req     (r1_req),
        .r1_we      (r1_we),
        .r1_addr    (r1_addr),
        .r1_wdata   (r1_wdata),
        .r1_wmsk    (r1_wmsk),
        .r1_gnt     (r1_gnt),
        .r1_rvalid  (r1_rvalid),
        .r1_rdata   (r1_rdata),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wmsk  (sram_wmsk),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .init_busy  (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro port model: mask bit 1 keeps the stored bit, read data registered
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen)
                mem[sram_addr] = (mem[sram_addr] & sram_wmsk) | (sram_wdata & ~sram_wmsk);
            else
                sram_rdata <= mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: pops expected read data on every rvalid, and checks idle/grant invariants
    always @(negedge clk) begin
        if (r0_rvalid) begin
            if (q0.size() == 0) check("r0 unexpected rvalid", 1, 0);
            else begin
                exp0 = q0.pop_front();
                check("r0 rdata", r0_rdata, exp0);
            end
        end
        if (r1_rvalid) begin
            if (q1.size() == 0) check("r1 unexpected rvalid", 1, 0);
            else begin
                exp1 = q1.pop_front();
                check("r1 rdata", r1_rdata, exp1);
            end
        end
        if (rst_n) begin
            check("single grant", r0_gnt & r1_gnt, 0);
            if (!r0_req && !r1_req && !init_busy)
                check("idle outputs", {sram_cen, sram_wen, sram_addr, sram_wmsk, sram_wdata},
                      {1'b1, 1'b1, 10'd0, 18'h3FFFF, 18'd0});
        end
    end

    task automatic set_cmd(input int n, input logic we, input logic [9:0] a,
                           input logic [17:0] d, input logic [17:0] m);
        if (n == 0) begin
            r0_we = we; r0_addr = a; r0_wdata = d; r0_wmsk = m; r0_req = 1'b1;
        end else begin
            r1_we = we; r1_addr = a; r1_wdata = d; r1_wmsk = m; r1_req = 1'b1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the acceptance edge
    task automatic issue(input int n, input logic we, input logic [9:0] a,
                         input logic [17:0] d, input logic [17:0] m, input logic [17:0] exp);
        logic got;
        got = 1'b0;
        set_cmd(n, we, a, d, m);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (n == 0) ? r0_gnt : r1_gnt;
        end
        check("grant", got, 1);
        if (got)
            check("sram cmd", {sram_cen, sram_wen, sram_addr, sram_wmsk, sram_wdata},
                  {1'b0, !we, a, m, d});
        @(posedge clk);
        #1;
        if (got && !we) begin
            if (n == 0) q0.push_back(exp);
            else q1.push_back(exp);
        end
        if (n == 0) r0_req = 1'b0;
        else r1_req = 1'b0;
        $display("txn r%0d %s addr=%0d wdata=%05h wmsk=%05h", n, we ? "WR" : "RD", a, d, m);
    endtask

    // Both requesters read continuously; grants must alternate starting with r0
    task automatic contend(input logic [9:0] a0, input logic [9:0] a1,
                           input logic [17:0] e0, input logic [17:0] e1);
        int k;
        int idle;
        logic [1:0] g;
        k = 0;
        idle = 0;
        set_cmd(0, 1'b0, a0, 18'd0, 18'h3FFFF);
        set_cmd(1, 1'b0, a1, 18'd0, 18'h3FFFF);
        while (k < 6 && idle < 40) begin
            @(negedge clk);
            g = {r1_gnt, r0_gnt};
            if (g != 2'b00) begin
                check("contention order", g, (k % 2 == 0) ? 2'b01 : 2'b10);
                @(posedge clk);
                #1;
                if (g[0]) q0.push_back(e0);
                else q1.push_back(e1);
                $display("txn contention grant %0d to r%0d", k, g[1] ? 1 : 0);
                k++;
            end else begin
                idle++;
            end
        end
        check("contention grant count", k, 6);
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    // Called at posedge+1 right after reset release
    task automatic init_wait();
        int cyc;
        int gnts;
        cyc = 0;
        gnts = 0;
        check("init first cmd", {sram_cen, sram_wen, sram_addr, sram_wmsk, sram_wdata},
              {1'b0, 1'b0, 10'd0, 18'd0, 18'd0});
        while (init_busy && cyc < 2000) begin
            if (r0_gnt || r1_gnt) gnts++;
            cyc++;
            @(posedge clk);
            #1;
        end
        check("init cycles", cyc, 1024);
        check("grants during init", gnts, 0);
        $display("txn zero-fill done after %0d cycles", cyc);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 18'h3FFFF;
        sram_rdata = '0;
        rst_n = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_wmsk = '1;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_wmsk = '1;
        set_cmd(0, 1'b0, 10'd0, 18'd0, 18'h3FFFF);
        set_cmd(1, 1'b0, 10'd1023, 18'd0, 18'h3FFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset gnt", {r1_gnt, r0_gnt}, 0);
        check("reset rvalid", {r1_rvalid, r0_rvalid}, 0);
        check("reset sram outputs", {sram_cen, sram_wen, sram_addr, sram_wmsk, sram_wdata},
              {1'b1, 1'b1, 10'd0, 18'h3FFFF, 18'd0});
        check("reset init_busy", init_busy, BUSY_RST);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
`ifdef SRAM1024X18_ARB_ZERO_INIT_EN
        init_wait();
`else
        check("init_busy tied low", init_busy, 0);
`endif
        contend(10'd0, 10'd1023, FILL, FILL);
        repeat (3) @(posedge clk);
        #1;

        issue(0, 1'b1, 10'd5, 18'h2AAAA, 18'h00000, 18'd0);
        issue(0, 1'b0, 10'd5, 18'd0, 18'h3FFFF, 18'h2AAAA);
        issue(1, 1'b1, 10'd7, 18'h3FFFF, 18'h00000, 18'd0);
        issue(1, 1'b1, 10'd7, 18'h00000, 18'h3FF00, 18'd0);
        issue(1, 1'b0, 10'd7, 18'd0, 18'h3FFFF, 18'h3FF00);
        issue(0, 1'b0, 10'd511, 18'd0, 18'h3FFFF, FILL);
        issue(1, 1'b0, 10'd300, 18'd0, 18'h3FFFF, FILL);
        contend(10'd5, 10'd7, 18'h2AAAA, 18'h3FF00);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-operation: a pending command must be deselected at once
        set_cmd(0, 1'b0, 10'd5, 18'd0, 18'h3FFFF);
`ifdef SRAM1024X18_ARB_ZERO_INIT_EN
        r0_req = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("mid-init busy before reset", init_busy, 1);
`endif
        rst_n = 1'b0;
        #1;
        check("async reset cen", sram_cen, 1);
        check("async reset gnt", {r1_gnt, r0_gnt}, 0);
        check("async reset rvalid", {r1_rvalid, r0_rvalid}, 0);
        check("async reset init_busy", init_busy, BUSY_RST);
        r0_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
`ifdef SRAM1024X18_ARB_ZERO_INIT_EN
        init_wait();
`endif
        issue(1, 1'b0, 10'd5, 18'd0, 18'h3FFFF, `ifdef SRAM1024X18_ARB_ZERO_INIT_EN 18'd0 `else 18'h2AAAA `endif);
        repeat (4) @(posedge clk);
        #1;
        check("r0 scoreboard drained", q0.size(), 0);
        check("r1 scoreboard drained", q1.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram1024x18_arbiter.md
# sram1024x18_arbiter

Two-requester round-robin arbiter and sequencer for one port of the `sram1024x18` dual-port macro. It takes single-word read/write commands from two clients over a req/gnt handshake and drives the macro's active-low `cen`/`wen`, address, write mask and write data. It returns read data with a one-cycle valid strobe. Optionally, it zero-fills the whole array after reset before it accepts any client traffic.

## Interface
- `ADDR_W`, default 10: word address width; fixed to the macro depth of 1024.
- `DATA_W`, default 18: word width; fixed to the macro width.
- `clk` in 1: single clock; shared with the macro port clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rN_req` in 1 (N = 0, 1): command request.
- `rN_we` in 1: 1 = write, 0 = read.
- `rN_addr` in ADDR_W: word address.
- `rN_wdata` in DATA_W: write data.
- `rN_wmsk` in DATA_W: per-bit mask; 1 = bit kept, 0 = bit written (macro polarity).
- `rN_gnt` out 1: command accepted this cycle.
- `rN_rvalid` out 1: `rN_rdata` valid this cycle.
- `rN_rdata` out DATA_W: read data.
- `sram_cen` out 1: macro chip enable, active-low.
- `sram_wen` out 1: macro write enable, active-low.
- `sram_addr` out ADDR_W: macro address.
- `sram_wmsk` out DATA_W: macro write mask.
- `sram_wdata` out DATA_W: macro write data.
- `sram_rdata` in DATA_W: macro read data.
- `init_busy` out 1: zero-fill in progress.

## Operation
- FSM states are INIT and RUN.
  - INIT exists only with the macro defined.
  - Reset enters INIT if it exists, otherwise RUN.
- Arbitration in RUN:
  - `rN_gnt` is combinational from `req` and a priority pointer.
  - At most one grant per cycle.
  - If one requester asks, it is granted.
  - If both ask, the requester not granted last is granted.
  - The pointer updates on every grant.
  - After reset, r0 has priority.
- A command is accepted when `rN_req && rN_gnt`.
- On acceptance, the granted requester's fields drive `sram_*` combinationally in the same cycle: `sram_cen`=0, `sram_wen`=!we, and addr/wmsk/wdata. The macro captures them at the next edge.
- Idle cycle outputs: `sram_cen`=1, `sram_wen`=1, `sram_addr`=0, `sram_wmsk`=all ones, `sram_wdata`=0.
- Requesters hold req and fields stable until granted. Dropping req before grant is legal and is treated as cancelling the command.
- Reads:
  - `rN_rvalid` is registered and pulses for exactly one cycle, in the cycle after the acceptance edge.
  - `rN_rdata` = `sram_rdata` passthrough; its value is meaningful only while rvalid is high.
- Writes: no response strobe.
- Back-to-back commands from one requester are allowed every cycle.
- A read accepted in the cycle after a write to the same address returns the new data.

## Timing
- Reset values:
  - `rN_gnt`=0, `rN_rvalid`=0.
  - `sram_cen`=1, `sram_wen`=1, `sram_addr`=0, `sram_wmsk`=all ones, `sram_wdata`=0.
  - Priority pointer = r0.
  - `init_busy`=1 with the macro, 0 without.
- Read latency: accept in cycle T, rvalid in cycle T+1.
- Throughput: one command per cycle across both requesters.
- Under sustained contention the requesters alternate, so each is served at most every other cycle.
- Reset asserted mid-operation:
  - Outputs return to reset values immediately.
  - Any pending rvalid is dropped.
  - INIT restarts from address 0.

## Configuration
- Macro `SRAM1024X18_ARB_ZERO_INIT_EN`.
- Defined:
  - After reset, INIT writes 0 to addresses 0..1023, one per cycle: `sram_cen`=0, `sram_wen`=0, `sram_wmsk`=0, `sram_wdata`=0.
  - A 10-bit counter drives `sram_addr`.
  - `init_busy`=1 and all `gnt`=0 throughout INIT.
  - After the cycle with counter = 1023, the FSM moves to RUN and `init_busy` falls. Duration is exactly 1024 cycles.
- Undefined:
  - No INIT state and no counter; `init_busy` tied to 0.
  - Arbitration begins in the first cycle after reset release.

## Structure
- Package `sram_arb_pkg` holds:
  - `ADDR_W`, `DATA_W`, `DEPTH`=1024.
  - The FSM state enum {INIT, RUN}.
  - The command struct {we, addr, wdata, wmsk}.
- Sub-module `rr_arb2`: two-way round-robin grant logic with pointer register; inputs req[1:0] and enable, output gnt[1:0].
- Top-level logic:
  - The INIT FSM and counter.
  - The command mux to `sram_*`.
  - The rvalid registers.

## Test plan
- **Zero-fill (macro defined):** preload the model with 0x3FFFF, release reset. Require `init_busy` high for exactly 1024 cycles and no grants during it; reading addresses 0, 511 and 1023 then returns 0.
- **Single-requester write/read:** r0 writes 0x2AAAA to address 5 with wmsk=0, then reads address 5 the next cycle. Require rvalid in the cycle after the read's acceptance, with rdata = 0x2AAAA.
- **Masked write:** address 7 holds 0x3FFFF; write 0x00000 with wmsk=0x3FF00. The subsequent read returns 0x3FF00.
- **Contention:** both requesters hold req for 6 cycles after reset. Require grants r0, r1, r0, r1, r0, r1, each rvalid returning to the correct requester, and never two grants in one cycle.
- **Reset mid-init:** assert `rst_n` at init cycle 300. Require `sram_cen`=1 immediately; after release, INIT restarts at address 0 and lasts a full 1024 cycles.
- **Idle outputs:** with no req, require `sram_cen`=1, `sram_wen`=1 and `sram_wmsk`=0x3FFFF on every cycle.
